// File: rtl/aes_loader_pkg.sv
// Shared types and widths for the AES stream loader.
package aes_loader_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned WORDS_PER_BLK = 4;
  localparam int unsigned BLK_W         = WORD_W * WORDS_PER_BLK;
  localparam int unsigned WCNT_W        = $clog2(WORDS_PER_BLK);

  typedef enum logic [1:0] {
    LOAD_KEY  = 2'd0,
    LOAD_DATA = 2'd1,
    RUN       = 2'd2,
    OUT       = 2'd3
  } state_e;

  // Result payload presented on the output port.
  typedef struct packed {
    logic             err;
    logic [BLK_W-1:0] data;
  } result_t;

endpackage

// File: rtl/aes_stream_loader.sv
// Word-stream front end and result back end around an AES core: loads key and
// plaintext, runs the core out of reset, and returns the result or a timeout.
module aes_stream_loader
  import aes_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BLK_W-1:0]  out_data,
  output logic              out_err,
  output logic              busy,
  output logic [BLK_W-1:0]  core_key,
  output logic [BLK_W-1:0]  core_data,
  output logic              core_rst_n,
  input  logic              core_finished,
  input  logic [BLK_W-1:0]  core_data_out
);

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLK_W-1:0]   key_q, key_d;
  logic [BLK_W-1:0]   data_q, data_d;
  result_t            res_q, res_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               core_rst_n_q, core_rst_n_d;

  logic accept;
  logic last_word;

  assign accept    = in_valid & in_ready_q;
  assign last_word = (wcnt_q == WCNT_W'(WORDS_PER_BLK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD_KEY;
      wcnt_q       <= '0;
      cnt_q        <= '0;
      key_q        <= '0;
      data_q       <= '0;
      res_q        <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      cnt_q        <= cnt_d;
      key_q        <= key_d;
      data_q       <= data_d;
      res_q        <= res_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    cnt_d        = cnt_q;
    key_d        = key_q;
    data_d       = data_q;
    res_d        = res_q;
    core_rst_n_d = core_rst_n_q;

    case (state_q)
      LOAD_KEY: begin
        if (accept) begin
          key_d = {key_q[BLK_W-WORD_W-1:0], in_word};
          if (last_word) begin
            wcnt_d  = '0;
            state_d = LOAD_DATA;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
      LOAD_DATA: begin
        if (accept) begin
          data_d = {data_q[BLK_W-WORD_W-1:0], in_word};
          if (last_word) begin
            wcnt_d       = '0;
            cnt_d        = '0;
            core_rst_n_d = 1'b1;
            state_d      = RUN;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A finished seen on the first run cycle may be left over from the core reset.
        if (core_finished && (cnt_q != '0)) begin
          res_d.data   = core_data_out;
          res_d.err    = 1'b0;
          core_rst_n_d = 1'b0;
          state_d      = OUT;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
          res_d.data   = '0;
          res_d.err    = 1'b1;
          core_rst_n_d = 1'b0;
          state_d      = OUT;
        end
      end
      OUT: begin
        if (out_valid_q && out_ready) begin
          wcnt_d  = '0;
          key_d   = '0;
          data_d  = '0;
          state_d = LOAD_KEY;
        end
      end
      default: state_d = LOAD_KEY;
    endcase

    in_ready_d  = (state_d == LOAD_KEY) || (state_d == LOAD_DATA);
    out_valid_d = (state_d == OUT);
    busy_d      = !((state_d == LOAD_KEY) && (wcnt_d == '0));
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = res_q.data;
  assign out_err    = res_q.err;
  assign busy       = busy_q;
  assign core_key   = key_q;
  assign core_data  = data_q;
  assign core_rst_n = core_rst_n_q;

endmodule

// File: tb/tb_aes_stream_loader.sv
// Bench for aes_stream_loader with a behavioural AES-128 core model attached.
module tb_aes_stream_loader;

  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned LAT     = 12;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] STALE  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]  in_word;
  logic [127:0] out_data, core_key, core_data, core_data_out;
  logic         out_err, busy, core_rst_n, core_finished;

  int errors = 0;
  int checks = 0;

  aes_stream_loader #(.TIMEOUT_CYC(TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .busy(busy),
    .core_key(core_key), .core_data(core_data), .core_rst_n(core_rst_n),
    .core_finished(core_finished), .core_data_out(core_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- AES-128 reference model ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [4];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int j = 0; j < 4; j++) w[j] = key[127-32*j -: 32];
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      tmp = w[3];
      tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
      rc = xt(rc);
      w[0] = w[0] ^ tmp; w[1] = w[1] ^ w[0]; w[2] = w[2] ^ w[1]; w[3] = w[3] ^ w[2];
      for (int i = 0; i < 16; i++) t[i] = sbox[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
          s[4*c+3] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- core model: 0 normal, 1 never finishes, 2 stale finished ----------------
  logic [1:0]   mode;
  int           run_cyc;
  logic [127:0] core_res;

  always @(posedge clk or negedge rst_n)
    if (!rst_n || !core_rst_n) run_cyc <= 0;
    else                       run_cyc <= run_cyc + 1;

  always @(negedge clk) core_res <= aes_enc(core_key, core_data);

  assign core_finished = core_rst_n &&
                         ((mode == 2'd0) ? (run_cyc >= int'(LAT)) :
                          (mode == 2'd2) ? (run_cyc == 0 || run_cyc >= 10) : 1'b0);
  assign core_data_out = (mode == 2'd2 && run_cyc == 0) ? STALE : core_res;

  // ---------------- monitors ----------------
  int           cyc = 0;
  int           run_total = 0;
  int           stab_viol = 0;
  logic         run_seen = 1'b0;
  logic [255:0] snap;
  logic [128:0] res_q [$];
  int           hs_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      res_q.push_back({out_err, out_data});
      hs_q.push_back(cyc);
    end
    if (core_rst_n) begin
      run_total <= run_total + 1;
      if (run_seen && {core_key, core_data} !== snap) stab_viol <= stab_viol + 1;
      snap     <= {core_key, core_data};
      run_seen <= 1'b1;
    end else begin
      run_seen <= 1'b0;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_word(input logic [31:0] w, output int acc);
    bit done;
    int n;
    done = 0; n = 0; acc = -1;
    in_valid = 1'b1;
    in_word  = w;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin done = 1; acc = cyc; end
      @(posedge clk); #1;
      n++;
      if (!done && n > 400) begin
        checks++; errors++;
        $display("FAIL send_word: word %h not accepted within %0d cycles", w, n);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] key, input logic [127:0] pt,
                            input bit gaps, output int first_acc);
    logic [255:0] all;
    int a;
    all = {key, pt};
    first_acc = -1;
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      send_word(all[255-32*i -: 32], a);
      if (i == 0) first_acc = a;
    end
  endtask

  task automatic wait_results(input int n);
    int k;
    k = 0;
    while (res_q.size() < n && k < 2000) begin @(posedge clk); #1; k++; end
    if (res_q.size() < n) begin
      checks++; errors++;
      $display("FAIL wait_results: have %0d results, need %0d", res_q.size(), n);
    end
  endtask

  task automatic wait_out_valid();
    int k;
    k = 0;
    while (!out_valid && k < 2000) begin @(posedge clk); #1; k++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL wait_out_valid: out_valid never rose");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b0; mode = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_data, out_err, busy, core_key, core_data, core_rst_n} !== '0) begin
      errors++;
      $display("FAIL reset_async: got rdy=%b ov=%b od=%h err=%b busy=%b key=%h data=%h crst=%b, want all 0",
               in_ready, out_valid, out_data, out_err, busy, core_key, core_data, core_rst_n);
    end
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if ({in_ready, out_valid, busy, core_rst_n} !== 4'b0) begin
      errors++;
      $display("FAIL reset_hold: got rdy=%b ov=%b busy=%b crst=%b, want 0", in_ready, out_valid, busy, core_rst_n);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, busy, core_rst_n, out_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b busy=%b crst=%b ov=%b, want 1 0 0 0",
               in_ready, busy, core_rst_n, out_valid);
    end
  endtask

  task automatic test_fips_c1();
    int a, r0, base;
    out_ready = 1'b1; mode = 2'd0;
    base = res_q.size();
    r0 = run_total;
    send_block(C1_KEY, C1_PT, 1'b0, a);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL c1_busy: got %b, want 1", busy);
    end
    wait_results(base + 1);
    checks++;
    if (res_q.size() > base && res_q[base] !== {1'b0, C1_CT}) begin
      errors++; $display("FAIL c1_result: got %h, want %h", res_q[base], {1'b0, C1_CT});
    end
    checks++;
    if (run_total - r0 !== int'(LAT) + 1) begin
      errors++; $display("FAIL c1_run_cycles: got %0d, want %0d", run_total - r0, LAT + 1);
    end
    checks++;
    if ({out_valid, in_ready, busy, core_rst_n, core_key, core_data} !== {4'b0100, 256'h0}) begin
      errors++;
      $display("FAIL c1_after_hs: got ov=%b rdy=%b busy=%b crst=%b key=%h data=%h, want 0 1 0 0 0 0",
               out_valid, in_ready, busy, core_rst_n, core_key, core_data);
    end
  endtask

  task automatic test_back_to_back();
    int a0, a1, base, hbase;
    out_ready = 1'b1; mode = 2'd0;
    base = res_q.size(); hbase = hs_q.size();
    send_block(C1_KEY, C1_PT, 1'b0, a0);
    send_block(B_KEY, B_PT, 1'b0, a1);
    wait_results(base + 2);
    if (res_q.size() >= base + 2) begin
      checks++;
      if (res_q[base] !== {1'b0, C1_CT}) begin
        errors++; $display("FAIL b2b_first: got %h, want %h", res_q[base], {1'b0, C1_CT});
      end
      checks++;
      if (res_q[base+1] !== {1'b0, B_CT}) begin
        errors++; $display("FAIL b2b_second: got %h, want %h", res_q[base+1], {1'b0, B_CT});
      end
      checks++;
      if (a1 !== hs_q[hbase] + 1) begin
        errors++; $display("FAIL b2b_accept_cycle: got %0d, want %0d", a1, hs_q[hbase] + 1);
      end
    end
  endtask

  task automatic test_stalls();
    int a, base, bad;
    logic [127:0] held;
    out_ready = 1'b0; mode = 2'd0;
    base = res_q.size();
    send_block(C1_KEY, C1_PT, 1'b1, a);
    wait_out_valid();
    held = out_data;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || out_data !== held) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL stall_hold: got %0d unstable cycles, want 0", bad);
    end
    checks++;
    if (held !== C1_CT || out_err !== 1'b0) begin
      errors++; $display("FAIL stall_data: got %h err=%b, want %h err=0", held, out_err, C1_CT);
    end
    out_ready = 1'b1;
    wait_results(base + 1);
    checks++;
    if (res_q.size() > base && res_q[base] !== {1'b0, C1_CT}) begin
      errors++; $display("FAIL stall_result: got %h, want %h", res_q[base], {1'b0, C1_CT});
    end
  endtask

  task automatic test_random();
    int a, base;
    logic [127:0] k, p;
    mode = 2'd0;
    for (int b = 0; b < 4; b++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'b0;
      base = res_q.size();
      send_block(k, p, 1'b1, a);
      wait_out_valid();
      repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      wait_results(base + 1);
      checks++;
      if (res_q.size() > base && res_q[base] !== {1'b0, aes_enc(k, p)}) begin
        errors++; $display("FAIL random_%0d: got %h, want %h", b, res_q[base], {1'b0, aes_enc(k, p)});
      end
    end
  endtask

  task automatic test_timeout();
    int a, r0, base;
    out_ready = 1'b0; mode = 2'd1;
    base = res_q.size();
    r0 = run_total;
    send_block(C1_KEY, C1_PT, 1'b0, a);
    wait_out_valid();
    checks++;
    if ({out_err, out_data, core_rst_n} !== {1'b1, 128'h0, 1'b0}) begin
      errors++; $display("FAIL timeout_out: got err=%b data=%h crst=%b, want 1 0 0", out_err, out_data, core_rst_n);
    end
    checks++;
    if (run_total - r0 !== int'(TIMEOUT) + 1) begin
      errors++; $display("FAIL timeout_cycles: got %0d, want %0d", run_total - r0, TIMEOUT + 1);
    end
    checks++;
    if (stab_viol !== 0) begin
      errors++; $display("FAIL operand_stability: got %0d changes during run, want 0", stab_viol);
    end
    out_ready = 1'b1;
    wait_results(base + 1);
    mode = 2'd0;
  endtask

  task automatic test_reset_mid();
    int a, base;
    logic [255:0] all;
    out_ready = 1'b1; mode = 2'd0;
    all = {C1_KEY, C1_PT};
    for (int i = 0; i < 5; i++) send_word(all[255-32*i -: 32], a);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_data, out_err, busy, core_key, core_data, core_rst_n} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b ov=%b od=%h err=%b busy=%b key=%h data=%h crst=%b, want all 0",
               in_ready, out_valid, out_data, out_err, busy, core_key, core_data, core_rst_n);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = res_q.size();
    send_block(C1_KEY, C1_PT, 1'b0, a);
    wait_results(base + 1);
    checks++;
    if (res_q.size() > base && res_q[base] !== {1'b0, C1_CT}) begin
      errors++; $display("FAIL reset_mid_result: got %h, want %h", res_q[base], {1'b0, C1_CT});
    end
  endtask

  task automatic test_stale_finished();
    int a, r0, base;
    out_ready = 1'b1; mode = 2'd2;
    base = res_q.size();
    r0 = run_total;
    send_block(C1_KEY, C1_PT, 1'b0, a);
    wait_results(base + 1);
    checks++;
    if (res_q.size() > base && res_q[base] !== {1'b0, C1_CT}) begin
      errors++; $display("FAIL stale_result: got %h, want %h", res_q[base], {1'b0, C1_CT});
    end
    checks++;
    if (run_total - r0 !== 11) begin
      errors++; $display("FAIL stale_run_cycles: got %0d, want 11", run_total - r0);
    end
    mode = 2'd0;
  endtask

  initial begin
    test_reset();
    test_fips_c1();
    test_back_to_back();
    test_stalls();
    test_random();
    test_timeout();
    test_reset_mid();
    test_stale_finished();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
